// File: rtl/tmr_apb_regif.sv
// tmr_apb_regif: APB3 completer and TDR/TCR/TSR register bank for the timer core
module tmr_apb_regif #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr,
  output logic              tdr_wr,
  output logic [7:0]        tcr,
  input  logic              ovf_set,
  input  logic              udf_set,
  output logic [1:0]        tsr
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [7:0] TCR_MASK = 8'b1011_0011;
  logic [1:0] state, phase;
  logic [2:0] cnt;
  logic [7:0] rd_mux;
  logic sel_tdr, sel_tcr, sel_tsr, err, wr_en;
  // SETUP is the bus setup cycle itself, so it is decoded live from psel/penable
  // while the register only remembers whether the next cycle is ACCESS.
  assign phase   = state == ACCESS ? ACCESS : (psel && !penable ? SETUP : IDLE);
  assign sel_tdr = paddr == ADDR_W'(0);
  assign sel_tcr = paddr == ADDR_W'(1);
  assign sel_tsr = paddr == ADDR_W'(2);
  assign err     = !(sel_tdr || sel_tcr || sel_tsr);
  assign pready  = phase == ACCESS && psel && penable && cnt == 3'd0;
  assign pslverr = pready && err;
  assign wr_en   = pready && pwrite && !err;
  always_comb
    rd_mux = sel_tdr ? tdr : sel_tcr ? tcr : sel_tsr ? {6'b0, tsr} : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      tdr    <= 8'h00;
      tcr    <= 8'h00;
      tsr    <= 2'b00;
      tdr_wr <= 1'b0;
      prdata <= 8'h00;
    end else begin
      state  <= phase == SETUP ? ACCESS :
                (phase == ACCESS && psel && penable && !pready) ? ACCESS : IDLE;
      cnt    <= phase == SETUP ? 3'(WAIT_STATES) :
                (phase == ACCESS && cnt != 3'd0) ? cnt - 3'd1 : cnt;
      tdr    <= wr_en && sel_tdr ? pwdata : tdr;
      tdr_wr <= wr_en && sel_tdr;
      tcr    <= wr_en && sel_tcr ? pwdata & TCR_MASK : tcr;
      // a hardware event on the same edge as a software clear keeps the bit set
      tsr    <= {udf_set, ovf_set} | (tsr & ~(wr_en && sel_tsr ? pwdata[1:0] : 2'b00));
      // preload read data before the completing cycle so it is valid with pready
      prdata <= (phase == SETUP || (phase == ACCESS && !pready)) && !pwrite ? rd_mux : prdata;
    end
  end
endmodule
